muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named clk_i and rst_ni.
REQ-002 Port clk_i, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-004 Port start_i, input, 1 bit: request valid, sampled on the rising edge.
REQ-005 Port funct3_i, input, 3 bits: operation selector (RV32M encoding, REQ-011).
REQ-006 Port rs1_data_i, input, 32 bits: operand A, taken from register-file read port 1.
REQ-007 Port rs2_data_i, input, 32 bits: operand B, taken from register-file read port 2.
REQ-008 Port rd_addr_i, input, 5 bits: destination register index.
REQ-009 Port busy_o, output, 1 bit: operation in progress; upstream holds the pipeline while high.
REQ-010 Ports rd_wren_o (1 bit), rd_addr_o (5 bits) and rd_data_o (32 bits), outputs: result write port; they connect directly to the register-file write inputs.

Function
REQ-011 funct3 decoding SHALL be: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-012 The FSM SHALL have three states:
- IDLE: on start_i=1, go to CALC.
- CALC: go to FINISH after exactly 32 iteration edges.
- FINISH: go to IDLE after one cycle.
REQ-013 At the accepting edge, the block SHALL latch funct3_i, rd_addr_i and the operand magnitudes: absolute values for signed operands, raw values for unsigned operands.
REQ-014 At the accepting edge, the block SHALL also latch the result sign.
REQ-015 A 6-bit iteration counter SHALL reset to 0 on acceptance and increment once per CALC edge.
REQ-016 Multiply SHALL use shift-add, one bit per cycle, into a 64-bit accumulator.
- MUL returns bits [31:0].
- MULH, MULHSU and MULHU return bits [63:32] after sign correction.
REQ-017 Divide SHALL use restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
REQ-018 Sign correction SHALL be applied in FINISH:
- Quotient is negated when the operand signs differ (signed ops only).
- Remainder takes the sign of the dividend.
REQ-019 Divide by zero SHALL return quotient 0xFFFFFFFF and remainder equal to rs1.
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL return quotient 0x80000000 and remainder 0.
REQ-021 Latency SHALL be fixed for all operations, including the special cases: 32 cycles from the accepting edge to the cycle in which FINISH is active.
REQ-022 rd_wren_o SHALL be high only during FINISH, for exactly one cycle, and only when the latched rd_addr is non-zero.
REQ-023 rd_data_o and rd_addr_o SHALL be valid and stable throughout FINISH, and SHALL be 0 in all other states.
REQ-024 busy_o SHALL be high in CALC and FINISH, and low in IDLE.
REQ-025 start_i SHALL be ignored while busy_o=1; no queuing.
REQ-026 start_i in the cycle FINISH is active SHALL be ignored; a new request is accepted only from IDLE.
REQ-027 Operand inputs SHALL be don't-care after the accepting edge.

Reset
REQ-028 While rst_ni=0, the block SHALL force:
- state to IDLE, counter to 0, accumulators to 0;
- busy_o=0, rd_wren_o=0, rd_addr_o=0, rd_data_o=0.
REQ-029 Reset asserted mid-operation SHALL abort the operation without any write.
REQ-030 After reset release, the first edge with start_i=1 SHALL be accepted.

Structure
REQ-031 The shared package SHALL hold:
- the muldiv_op enum (8 values, REQ-011);
- the constants MULDIV_ITER=32 and XLEN=32.
REQ-032 The block SHALL be a single module with no sub-modules; the sign pre- and post-processing is combinational logic inside it.

Verification
REQ-033 MUL, rs1=7, rs2=0xFFFFFFFD, rd=5 -> FINISH 32 cycles after acceptance; rd_wren_o=1, rd_addr_o=5, rd_data_o=0xFFFFFFEB.
REQ-034 MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-035 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-036 Special cases:
- DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 / 0 -> 100.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-037 Reset and start handling:
- start_i pulsed at CALC iteration 5 -> ignored, one result only.
- rst_ni pulled low at iteration 10 -> busy_o=0 immediately and no rd_wren_o pulse.
- Next start after reset completes normally.
REQ-038 MUL with rd=0 -> busy_o profile identical to REQ-033 and rd_wren_o stays 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared RV32M operation encoding and iteration constants
package muldiv_pkg;
  localparam int XLEN = 32;
  localparam int MULDIV_ITER = 32;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, 32 iterations then a one-cycle register write
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  output logic        busy_o,
  output logic        rd_wren_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o
);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;
  state_e state;
  muldiv_op_e op, fin;
  logic [5:0] cnt;
  logic [4:0] rd;
  logic [XLEN-1:0] opd, a_mag, b_mag, quo, rmd, result;
  logic [63:0] acc, acc_nxt, prod;
  logic [32:0] rem, rem_nxt, r_sh, diff, mul_sum;
  logic neg_res, neg_rem, a_neg, b_neg, in_div, is_div;
  assign fin = muldiv_op_e'(funct3_i);
  assign in_div = funct3_i[2];
  assign a_neg = (fin inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & rs1_data_i[31];
  assign b_neg = (fin inside {OP_MULH, OP_DIV, OP_REM}) & rs2_data_i[31];
  assign a_mag = a_neg ? -rs1_data_i : rs1_data_i;
  assign b_mag = b_neg ? -rs2_data_i : rs2_data_i;
  assign is_div = op[2];
  // Multiply keeps the multiplier in the low half and shifts the growing product in from the top
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
  assign r_sh = {rem[31:0], acc[31]};
  assign diff = r_sh - {1'b0, opd};
  assign acc_nxt = is_div ? {32'd0, acc[30:0], ~diff[32]} : {mul_sum, acc[31:1]};
  assign rem_nxt = is_div && !diff[32] ? diff : r_sh;
  assign prod = neg_res ? -acc_nxt : acc_nxt;
  assign quo = neg_res ? -acc_nxt[31:0] : acc_nxt[31:0];
  assign rmd = neg_rem ? -rem_nxt[31:0] : rem_nxt[31:0];
  assign result = op == OP_MUL ? prod[31:0] : !is_div ? prod[63:32] : op[1] ? rmd : quo;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      op <= OP_MUL;
      cnt <= '0;
      rd <= '0;
      opd <= '0;
      acc <= '0;
      rem <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      busy_o <= 1'b0;
      rd_wren_o <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state <= CALC;
          op <= fin;
          rd <= rd_addr_i;
          cnt <= '0;
          opd <= in_div ? b_mag : a_mag;
          acc <= {32'd0, in_div ? a_mag : b_mag};
          rem <= '0;
          // Divide by zero keeps the all-ones quotient unsigned; remainder still follows the dividend
          neg_res <= (a_neg ^ b_neg) & ~(in_div & (rs2_data_i == '0));
          neg_rem <= a_neg;
          busy_o <= 1'b1;
        end
        CALC: begin
          acc <= acc_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(MULDIV_ITER - 1)) begin
            state <= FINISH;
            rd_wren_o <= rd != '0;
            rd_addr_o <= rd;
            rd_data_o <= result;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy_o <= 1'b0;
          rd_wren_o <= 1'b0;
          rd_addr_o <= '0;
          rd_data_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
